// File: rtl/data_bus_arbiter_pkg.sv
// Shared types for the two-master data bus arbiter.
// Imported by the interface, the round-robin picker and the top.
package bus_arb_pkg;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  typedef logic midx_t;

  localparam logic [31:0] ERR_DATA_DEF = 32'h0000_0000;

endpackage

// File: rtl/data_bus_arbiter_if.sv
// Handshake bundles: one per requesting master and one for
// the shared memory/peripheral bus.
interface dba_mst_if;
  logic        req;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        done;
  logic        err;
  logic [31:0] rdata;

  modport master (
    output req, wr, addr, wdata,
    input  gnt, done, err, rdata
  );

  modport slave (
    input  req, wr, addr, wdata,
    output gnt, done, err, rdata
  );
endinterface

interface dba_bus_if;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  modport master (
    output rd, wr, addr, wdata,
    input  rdata, ready
  );

  modport slave (
    input  rd, wr, addr, wdata,
    output rdata, ready
  );
endinterface

// File: rtl/data_bus_arbiter_rr.sv
// Two-way round-robin picker with a last-served pointer.
// The pointer resets to m1 so m0 wins the first tie.
module rr_arbiter2
  import bus_arb_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  req0_i,
  input  logic  req1_i,
  input  logic  en_i,
  output midx_t win_o,
  output logic  any_o
);

  midx_t last_q;

  assign any_o = req0_i | req1_i;

  // Tie goes to whoever was not served last.
  always_comb begin
    win_o = 1'b0;
    if (req0_i && req1_i)
      win_o = ~last_q;
    else if (req1_i)
      win_o = 1'b1;
  end

  // Remember the winner whenever a grant is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last_q <= 1'b1;
    else if (en_i)
      last_q <= win_o;
  end

endmodule

// File: rtl/data_bus_arbiter.sv
// Shares the data bus between CPU (m0) and UART DMA (m1):
// grants one request, holds the strobe until ready or timeout.
module data_bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic     clk,
  input  logic     reset,
  dba_mst_if.slave m0,
  dba_mst_if.slave m1,
  dba_bus_if.master s
);

  localparam int CW =
    (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TCNT = CW'(TIMEOUT);

  state_t             state_q;
  midx_t              win_q;
  logic               cwr_q;
  logic [CW-1:0]      cnt_q;
  logic [1:0]         gnt_q;
  logic [1:0]         done_q;
  logic [1:0]         err_q;
  logic [1:0][31:0]   rdata_q;
  logic               srd_q;
  logic               swr_q;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;

  midx_t       win;
  logic        any;
  logic        grant;
  logic        wr_d;
  logic [31:0] addr_d;
  logic [31:0] wdata_d;
  logic        tmo;

  assign grant = (state_q == IDLE) && any;
  assign tmo   = (TIMEOUT != 0) && (cnt_q == TCNT);

  rr_arbiter2 u_rr (
    .clk    (clk),
    .rst_n  (reset),
    .req0_i (m0.req),
    .req1_i (m1.req),
    .en_i   (grant),
    .win_o  (win),
    .any_o  (any)
  );

  // Payload of whichever master wins this cycle.
  always_comb begin
    wr_d    = win ? m1.wr    : m0.wr;
    addr_d  = win ? m1.addr  : m0.addr;
    wdata_d = win ? m1.wdata : m0.wdata;
  end

  // Sequencer: grant in IDLE, complete on ready or timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      win_q   <= 1'b0;
      cwr_q   <= 1'b0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      rdata_q <= '0;
      srd_q   <= 1'b0;
      swr_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      gnt_q  <= '0;
      done_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (grant) begin
            state_q    <= ACCESS;
            win_q      <= win;
            gnt_q[win] <= 1'b1;
            cwr_q      <= wr_d;
            srd_q      <= ~wr_d;
            swr_q      <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= '0;
          end
        end
        ACCESS: begin
          if (s.ready) begin
            state_q       <= IDLE;
            done_q[win_q] <= 1'b1;
            err_q[win_q]  <= 1'b0;
            srd_q         <= 1'b0;
            swr_q         <= 1'b0;
            if (!cwr_q)
              rdata_q[win_q] <= s.rdata;
          end else if (tmo) begin
            state_q       <= IDLE;
            done_q[win_q] <= 1'b1;
            err_q[win_q]  <= 1'b1;
            srd_q         <= 1'b0;
            swr_q         <= 1'b0;
            if (!cwr_q)
              rdata_q[win_q] <= ERR_DATA;
          end else if (cnt_q != TCNT) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m0.gnt   = gnt_q[0];
  assign m1.gnt   = gnt_q[1];
  assign m0.done  = done_q[0];
  assign m1.done  = done_q[1];
  assign m0.err   = err_q[0];
  assign m1.err   = err_q[1];
  assign m0.rdata = rdata_q[0];
  assign m1.rdata = rdata_q[1];
  assign s.rd     = srd_q;
  assign s.wr     = swr_q;
  assign s.addr   = addr_q;
  assign s.wdata  = wdata_q;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Bench for data_bus_arbiter: scoreboard of expected
// completions checked against every done pulse.
module tb_data_bus_arbiter;

  localparam logic [31:0] KEY = 32'h4000_00B5;

  typedef struct {
    int          m;
    logic        err;
    logic [31:0] rd;
    int          lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   acc_cnt;
  int   wait_n;
  int   nchk;
  int   nfail;
  int   gcyc [2];
  exp_t sb [$];

  dba_mst_if m0_if ();
  dba_mst_if m1_if ();
  dba_bus_if bus_if ();

  data_bus_arbiter #(.TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (rst_n),
    .m0    (m0_if),
    .m1    (m1_if),
    .s     (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cyc++;
    acc_cnt <= (bus_if.rd | bus_if.wr) ? acc_cnt + 1 : 0;
  end

  assign bus_if.rdata = bus_if.addr ^ KEY;
  assign bus_if.ready = (bus_if.rd | bus_if.wr) &&
                        (acc_cnt == wait_n);

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic gnt_of(input int m);
    return (m != 0) ? m1_if.gnt : m0_if.gnt;
  endfunction

  function automatic logic done_of(input int m);
    return (m != 0) ? m1_if.done : m0_if.done;
  endfunction

  task automatic set_m(input int m, input logic r,
                       input logic w, input logic [31:0] a,
                       input logic [31:0] d);
    if (m == 0) begin
      m0_if.req = r; m0_if.wr = w;
      m0_if.addr = a; m0_if.wdata = d;
    end else begin
      m1_if.req = r; m1_if.wr = w;
      m1_if.addr = a; m1_if.wdata = d;
    end
  endtask

  task automatic issue(input int m, input logic w,
                       input logic [31:0] a,
                       input logic [31:0] d,
                       output int n);
    set_m(m, 1'b1, w, a, d);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!gnt_of(m) && n < 64);
    if (!gnt_of(m)) chk("gnt_wait", 0, 1);
    set_m(m, 1'b0, w, a, d);
  endtask

  task automatic wait_done(input int m, input int budget);
    int k = 0;
    while (!done_of(m) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!done_of(m)) chk("done_wait", 0, 1);
  endtask

  task automatic master(input int m, input int n,
                        input logic [31:0] a);
    int w;
    for (int i = 0; i < n; i++) begin
      issue(m, 1'b0, a, 32'h0, w);
      wait_done(m, 64);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_m(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Scoreboard: every done pops the next expected completion.
  always @(negedge clk) begin
    exp_t e;
    int   m;
    logic [31:0] rd;
    if (m0_if.gnt | m1_if.gnt) begin
      chk("gnt_excl", {31'b0, m0_if.gnt & m1_if.gnt}, 0);
      if (m0_if.gnt) gcyc[0] = cyc;
      if (m1_if.gnt) gcyc[1] = cyc;
    end
    if (m0_if.done | m1_if.done) begin
      chk("done_excl", {31'b0, m0_if.done & m1_if.done}, 0);
      if (sb.size() == 0) begin
        chk("done_unexp", 1, 0);
      end else begin
        e  = sb.pop_front();
        m  = m1_if.done ? 1 : 0;
        rd = (m != 0) ? m1_if.rdata : m0_if.rdata;
        chk("done_mst", m, e.m);
        chk("done_err", {31'b0,
            (m != 0) ? m1_if.err : m0_if.err}, {31'b0, e.err});
        chk("done_rdata", rd, e.rd);
        chk("done_lat", cyc - gcyc[m], e.lat);
      end
    end
  end

  initial begin
    int w;
    nchk = 0; nfail = 0; cyc = 0;
    acc_cnt = 0; wait_n = 0;
    do_reset();

    chk("rst_gnt", {m1_if.gnt, m0_if.gnt}, 0);
    chk("rst_done", {m1_if.done, m0_if.done}, 0);
    chk("rst_err", {m1_if.err, m0_if.err}, 0);
    chk("rst_strb", {bus_if.rd, bus_if.wr}, 0);
    chk("rst_addr", bus_if.addr, 0);
    chk("rst_rd0", m0_if.rdata, 0);
    chk("rst_rd1", m1_if.rdata, 0);

    // Single zero-wait read.
    wait_n = 0;
    sb.push_back('{0, 1'b0, 32'h0000_00A5, 1});
    issue(0, 1'b0, 32'h4000_0010, 32'h0, w);
    chk("rd_gnt_lat", w, 1);
    chk("rd_srd", {31'b0, bus_if.rd}, 1);
    chk("rd_addr", bus_if.addr, 32'h4000_0010);
    wait_done(0, 8);
    @(negedge clk);

    // Round-robin with both masters re-requesting.
    do_reset();
    sb.push_back('{0, 1'b0, 32'h4000_0100 ^ KEY, 1});
    sb.push_back('{1, 1'b0, 32'h4000_0200 ^ KEY, 1});
    sb.push_back('{0, 1'b0, 32'h4000_0100 ^ KEY, 1});
    sb.push_back('{1, 1'b0, 32'h4000_0200 ^ KEY, 1});
    fork
      master(0, 2, 32'h4000_0100);
      master(1, 2, 32'h4000_0200);
    join
    @(negedge clk);

    // Write with three wait states; m1 rdata must hold.
    wait_n = 3;
    sb.push_back('{1, 1'b0, 32'h4000_0200 ^ KEY, 4});
    issue(1, 1'b1, 32'h4000_000C, 32'h0000_00FF, w);
    for (int i = 0; i < 4; i++) begin
      chk("wr_swr", {31'b0, bus_if.wr}, 1);
      chk("wr_addr", bus_if.addr, 32'h4000_000C);
      chk("wr_data", bus_if.wdata, 32'h0000_00FF);
      @(negedge clk);
    end
    chk("wr_drop", {31'b0, bus_if.wr}, 0);
    wait_done(1, 4);
    @(negedge clk);

    // Slave never answers: timeout completion.
    wait_n = 1000;
    sb.push_back('{0, 1'b1, 32'h0, 17});
    issue(0, 1'b0, 32'h4000_0020, 32'h0, w);
    wait_done(0, 40);

    // Ready on the terminal count wins; IDLE grant in 1 cycle.
    wait_n = 16;
    sb.push_back('{1, 1'b0, 32'h4000_0024 ^ KEY, 17});
    issue(1, 1'b0, 32'h4000_0024, 32'h0, w);
    chk("idle_after_to", w, 1);
    wait_done(1, 40);
    @(negedge clk);

    // Reset mid-access: strobe drops, no done.
    wait_n = 1000;
    issue(0, 1'b0, 32'h4000_0030, 32'h0, w);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_strb", {bus_if.rd, bus_if.wr}, 0);
    chk("mid_rst_rd1", m1_if.rdata, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    wait_n = 0;
    sb.push_back('{0, 1'b0, 32'h4000_0300 ^ KEY, 1});
    sb.push_back('{1, 1'b0, 32'h4000_0400 ^ KEY, 1});
    fork
      master(0, 1, 32'h4000_0300);
      master(1, 1, 32'h4000_0400);
    join
    repeat (3) @(negedge clk);

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/data_bus_arbiter.md
# data_bus_arbiter

Two-master arbiter and transaction sequencer sharing the single data memory/peripheral bus (data RAM, UART, LED, switch and digit registers) between the CPU load/store port (master 0) and a UART DMA engine (master 1). It sits between the masters and the memory/peripheral block. It accepts one request at a time, drives the shared bus until the slave reports ready or a timeout expires, then returns read data and a completion pulse to the winning master.

## Interface
- TIMEOUT, 16: cycles in ACCESS without `s_ready` before an error completion; 0 disables the timeout.
- ERR_DATA, 32'h0000_0000: read data returned on a timeout completion.

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- m0_req, m1_req  in  1  request; held with payload until the matching gnt is seen
- m0_wr, m1_wr  in  1  1 = write, 0 = read
- m0_addr, m1_addr  in  32  byte address
- m0_wdata, m1_wdata  in  32  write data
- m0_gnt, m1_gnt  out  1  one-cycle pulse: request accepted, payload captured
- m0_done, m1_done  out  1  one-cycle pulse: transaction complete
- m0_err, m1_err  out  1  valid with done; 1 = timed out
- m0_rdata, m1_rdata  out  32  read data, valid with done; held until the next done to that master
- s_rd, s_wr  out  1  bus read/write strobe, held for the whole access
- s_addr, s_wdata  out  32  captured address/data
- s_rdata  in  32  slave read data, sampled when `s_ready` is high
- s_ready  in  1  slave completes the access this cycle

## Operation
- States: IDLE, ACCESS.
- IDLE:
  - If any req is high at the edge, pick a winner and capture wr, addr and wdata.
  - Pulse that master's gnt, update the last-served pointer, go to ACCESS.
  - With no request, stay in IDLE.
- Arbitration: a single requester wins. If both request, the master not last served wins (round-robin). After reset the pointer reads "last served = m1", so m0 wins the first tie.
- ACCESS:
  - s_rd = !wr or s_wr = wr, with s_addr/s_wdata from the captures.
  - On `s_ready`: latch s_rdata into the winner's rdata (writes leave rdata unchanged), err = 0, pulse done, go to IDLE.
  - If the timeout counter reaches TIMEOUT with no ready: rdata = ERR_DATA for reads, err = 1, pulse done, go to IDLE.
- Req is ignored outside IDLE. A master deasserts req during its gnt cycle unless it is issuing a new request. A req still high at the next IDLE edge is treated as a new transaction.
- Timeout counter is $clog2(TIMEOUT+1) bits, cleared on entry to ACCESS, and saturates.
- Reset (any time, including mid-ACCESS) produces:
  - state IDLE, pointer = m1;
  - all gnt/done/err/s_rd/s_wr = 0; s_addr, s_wdata and both rdata = 0;
  - no done is issued for an aborted access.

## Timing
- Cycle 0: req is sampled at the end-of-cycle edge.
- Cycle 1: gnt and the bus strobe go high (all outputs registered).
- Earliest done: cycle 2, when `s_ready` is high in cycle 1. Each extra wait cycle adds one cycle.
- Timeout done is issued TIMEOUT+1 cycles after the gnt cycle.
- The done cycle is an IDLE cycle, so back-to-back transactions get gnt in the cycle after done. Sustained throughput is one access per 2 cycles at zero wait states.
- `s_ready` while in IDLE is ignored. If `s_ready` and the timeout terminal count coincide, `s_ready` wins (err = 0).

## Structure
- Package `bus_arb_pkg`:
  - state enum {IDLE, ACCESS};
  - master index type (1 bit);
  - default ERR_DATA constant.
- Sub-module `rr_arbiter2`: combinational winner select from the two reqs and the last-served pointer, plus pointer register update on a grant enable. All other logic lives in `data_bus_arbiter`.

## Test plan
- After reset, m0 read at 0x4000_0010 with `s_ready` in the first ACCESS cycle -> m0_gnt in cycle 1, s_rd in cycle 1, m0_done in cycle 2 with m0_rdata = s_rdata (e.g. 0x0000_00A5), err = 0.
- m0 and m1 request in the same cycle, both re-requesting after each done -> grants alternate m0, m1, m0, m1; strobes never overlap.
- m1 write 0x4000_000C/0x0000_00FF, `s_ready` delayed 3 cycles -> s_wr held 4 cycles with stable addr/data, m1_done 1 cycle later, m1_rdata unchanged.
- TIMEOUT = 16, `s_ready` never asserted -> done 17 cycles after gnt, err = 1, rdata = ERR_DATA, then IDLE.
- Reset asserted mid-ACCESS -> s_rd/s_wr drop immediately, no done. After release the first tie goes to m0.
- `s_ready` coinciding with the terminal timeout count -> err = 0, rdata = s_rdata.
